// File: rtl/stage_seq.sv
// stage_seq: tap/bias/data read sequencer feeding a 6-tap MAC; first result 8 cycles after start, 8 cycles per output.
// Result is held on out_valid until out_ready with no reads issued; define STAGE_SEQ_RELU_EN to clamp negative results to 0.
module stage_seq #(
  parameter int N_OUT     = 8,
  parameter int STRIDE    = 6,
  parameter int DATA_BASE = 0,
  parameter int FRAC      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         tap_rd_en,
  output logic [3:0]   tap_rd_addr,
  input  logic [191:0] tap_rd_data,
  output logic         bias_rd_en,
  output logic [2:0]   bias_rd_addr,
  input  logic [31:0]  bias_rd_data,
  output logic         data_rd_en,
  output logic [5:0]   data_rd_addr,
  input  logic [31:0]  data_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [2:0]   out_index
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]          n;
  logic [2:0]          j;
  logic [159:0]        tap_hi;
  logic signed [66:0]  acc;
  logic signed [66:0]  acc_base;
  logic signed [66:0]  acc_nxt;
  logic signed [66:0]  shifted;
  logic signed [66:0]  bias_ext;
  logic signed [66:0]  prod_ext;
  logic signed [63:0]  prod;
  logic signed [31:0]  lane_sel;
  logic signed [31:0]  data_s;
  logic [31:0]         sat_val;
  logic [31:0]         result;
  logic [5:0]          row_addr;
  logic                last;

  assign row_addr = 6'(DATA_BASE + int'(n) * STRIDE);
  assign last     = (n == 3'(N_OUT - 1));

  // Lane 0 comes straight off the read port in j=0; lanes 1..5 from the captured row.
  always_comb begin
    lane_sel = tap_rd_data[31:0];
    for (int k = 1; k < 6; k++) begin
      if (j == 3'(k)) lane_sel = tap_hi[32*(k-1) +: 32];
    end
  end

  assign data_s   = data_rd_data;
  assign prod     = lane_sel * data_s;
  assign prod_ext = {{3{prod[63]}}, prod};
  assign bias_ext = {{35{bias_rd_data[31]}}, bias_rd_data};
  assign acc_base = (j == 3'd0) ? (bias_ext <<< FRAC) : acc;
  assign acc_nxt  = acc_base + prod_ext;
  assign shifted  = acc_nxt >>> FRAC;

  always_comb begin
    if (shifted[66:31] != {36{shifted[66]}}) begin
      sat_val = shifted[66] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sat_val = shifted[31:0];
    end
`ifdef STAGE_SEQ_RELU_EN
    result = sat_val[31] ? 32'd0 : sat_val;
`else
    result = sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      n         <= '0;
      j         <= '0;
      tap_hi    <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: j <= '0;
        MAC: begin
          if (j == 3'd0) tap_hi <= tap_rd_data[191:32];
          acc <= acc_nxt;
          j   <= j + 3'd1;
          if (j == 3'd5) begin
            out_data  <= result;
            out_index <= n;
          end
        end
        OUT: begin
          if (out_ready && !last) n <= n + 3'd1;
        end
        DONE: n <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    tap_rd_en    = 1'b0;
    tap_rd_addr  = '0;
    bias_rd_en   = 1'b0;
    bias_rd_addr = '0;
    data_rd_en   = 1'b0;
    data_rd_addr = '0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy         = 1'b1;
        tap_rd_en    = 1'b1;
        tap_rd_addr  = {1'b0, n};
        bias_rd_en   = 1'b1;
        bias_rd_addr = n;
        data_rd_en   = 1'b1;
        data_rd_addr = row_addr;
        state_nxt    = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (j <= 3'd4) begin
          data_rd_en   = 1'b1;
          data_rd_addr = 6'(int'(row_addr) + int'(j) + 1);
        end
        if (j == 3'd5) state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = last ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage_seq.sv
// Scoreboarded bench for stage_seq: memory models, reference dot-product model, decoupled output/read monitor.
module tb_stage_seq;

  localparam int N  = 8;
  localparam int ST = 6;
  localparam int DB = 10;
  localparam int FR = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic         tap_rd_en;
  logic [3:0]   tap_rd_addr;
  logic [191:0] tap_rd_data = '0;
  logic         bias_rd_en;
  logic [2:0]   bias_rd_addr;
  logic [31:0]  bias_rd_data = '0;
  logic         data_rd_en;
  logic [5:0]   data_rd_addr;
  logic [31:0]  data_rd_data = '0;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_index;

  stage_seq #(.N_OUT(N), .STRIDE(ST), .DATA_BASE(DB), .FRAC(FR)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .tap_rd_en(tap_rd_en), .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tap_mem  [8][6];
  logic [31:0] bias_mem [8];
  logic [31:0] data_mem [64];

  logic [34:0] exp_q[$];
  logic [5:0]  daddr_q[$];
  logic [2:0]  taddr_q[$];

  bit          mon_en   = 1'b0;
  bit          held     = 1'b0;
  bit          exp_load = 1'b0;
  bit          exp_done = 1'b0;
  logic [31:0] held_dat = '0;
  logic [2:0]  held_idx = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    if (tap_rd_en) begin
      for (int k = 0; k < 6; k++) tap_rd_data[32*k +: 32] <= tap_mem[tap_rd_addr[2:0]][k];
    end
    if (bias_rd_en) bias_rd_data <= bias_mem[bias_rd_addr];
    if (data_rd_en) data_rd_data <= data_mem[data_rd_addr];
  end

  function automatic logic [31:0] model(input int n);
    logic signed [127:0] s, a, b;
    logic [31:0] r;
    a = $signed(bias_mem[n]);
    s = a <<< FR;
    for (int k = 0; k < 6; k++) begin
      a = $signed(tap_mem[n][k]);
      b = $signed(data_mem[DB + n*ST + k]);
      s = s + a * b;
    end
    s = s >>> FR;
    if (s > 128'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (s < -128'sd2147483648) r = 32'h8000_0000;
    else                            r = s[31:0];
`ifdef STAGE_SEQ_RELU_EN
    if (r[31]) r = 32'd0;
`endif
    return r;
  endfunction

  task automatic queue_run();
    for (int n = 0; n < N; n++) begin
      exp_q.push_back({3'(n), model(n)});
      taddr_q.push_back(3'(n));
      for (int k = 0; k < 6; k++) daddr_q.push_back(6'(DB + n*ST + k));
    end
  endtask

  task automatic clear_mem();
    for (int n = 0; n < 8; n++) begin
      bias_mem[n] = '0;
      for (int k = 0; k < 6; k++) tap_mem[n][k] = '0;
    end
    for (int a = 0; a < 64; a++) data_mem[a] = '0;
  endtask

  task automatic rand_mem();
    logic [31:0] r;
    for (int n = 0; n < 8; n++) begin
      r = $urandom();
      bias_mem[n] = {{8{r[23]}}, r[23:0]};
      for (int k = 0; k < 6; k++) begin
        r = $urandom();
        tap_mem[n][k] = {{14{r[17]}}, r[17:0]};
      end
    end
    for (int a = 0; a < 64; a++) begin
      r = $urandom();
      data_mem[a] = ($urandom_range(0, 3) == 0) ? r : {{11{r[20]}}, r[20:0]};
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_rd_en"},     64'({tap_rd_en, bias_rd_en, data_rd_en}), 64'd0);
    chk({tag, "_tap_addr"},  64'(tap_rd_addr), 64'd0);
    chk({tag, "_bias_addr"}, 64'(bias_rd_addr), 64'd0);
    chk({tag, "_data_addr"}, 64'(data_rd_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data), 64'd0);
    chk({tag, "_out_index"}, 64'(out_index), 64'd0);
  endtask

  // Monitor: read-address sequence, output scoreboard, stall stability, post-handshake behaviour.
  always @(negedge clk) begin
    logic [34:0] e;
    logic [5:0]  da;
    logic [2:0]  ta;
    if (reset || !mon_en) begin
      held     = 1'b0;
      exp_load = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_load) chk("load_after_handshake", 64'(tap_rd_en), 64'd1);
      if (exp_done) chk("done_after_last", 64'(done), 64'd1);
      exp_load = 1'b0;
      exp_done = 1'b0;
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(held_dat));
        chk("stall_index", 64'(out_index), 64'(held_idx));
      end
      if (tap_rd_en) begin
        if (taddr_q.size() == 0) begin
          chk("tap_read_unexpected", 64'(tap_rd_en), 64'd0);
        end else begin
          ta = taddr_q.pop_front();
          chk("tap_addr", 64'(tap_rd_addr), 64'({1'b0, ta}));
          chk("bias_en", 64'(bias_rd_en), 64'd1);
          chk("bias_addr", 64'(bias_rd_addr), 64'(ta));
        end
      end else if (bias_rd_en) begin
        chk("bias_without_tap", 64'(bias_rd_en), 64'd0);
      end
      if (data_rd_en) begin
        if (daddr_q.size() == 0) begin
          chk("data_read_unexpected", 64'(data_rd_en), 64'd0);
        end else begin
          da = daddr_q.pop_front();
          chk("data_addr", 64'(data_rd_addr), 64'(da));
        end
      end
      if (out_valid) chk("no_read_in_out", 64'({tap_rd_en, bias_rd_en, data_rd_en}), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[31:0]));
          chk("out_index", 64'(out_index), 64'(e[34:32]));
          if (e[34:32] == 3'(N - 1)) exp_done = 1'b1;
          else exp_load = 1'b1;
        end
      end
      held     = out_valid && !out_ready;
      held_dat = out_data;
      held_idx = out_index;
    end
  end

  // mode 0: ready high; 1: 5-cycle stall at output 3; 2: random ready; 3: start pulsed while busy
  task automatic do_run(input int mode);
    int cyc, stall_left, stalls, first_v;
    queue_run();
    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cyc        = 1;
    stall_left = 5;
    stalls     = 0;
    first_v    = -1;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!done && cyc < 2000) begin
      if (out_valid && first_v < 0) first_v = cyc;
      if (mode == 1 && out_valid && out_index == 3'd3 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && !out_ready) stalls++;
      start = (mode == 3 && cyc == 12);
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("done_cycle", 64'(cyc), 64'(8*N + 1 + stalls));
    chk("first_valid_cycle", 64'(first_v), 64'd8);
    if (mode == 1) chk("stall_cycles", 64'(stalls), 64'd5);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("data_reads_complete", 64'(daddr_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Unit taps, data 1..6 per output: every result is 21.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 6; k++) begin
        tap_mem[n][k] = 32'h0001_0000;
        data_mem[DB + n*ST + k] = 32'(k + 1);
      end
    end
    do_run(0);

    // Bias plus a negative product.
    clear_mem();
    bias_mem[0]   = 32'd5;
    tap_mem[0][0] = 32'h0001_0000;
    data_mem[DB]  = 32'hFFFF_FFFD;
    do_run(0);
    bias_mem[0] = 32'd1;
    do_run(0);

    // Saturation, positive then negative.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 6; k++) tap_mem[n][k] = 32'h7FFF_FFFF;
    end
    for (int a = 0; a < 64; a++) data_mem[a] = 32'h7FFF_FFFF;
    do_run(0);
    for (int a = 0; a < 64; a++) data_mem[a] = 32'h8000_0001;
    do_run(0);

    rand_mem();
    do_run(1);
    rand_mem();
    do_run(2);
    rand_mem();
    do_run(2);

    rand_mem();
    do_run(3);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_ignored_start", 64'(busy), 64'd0);

    // Reset in the middle of output 2's MAC phase, then a clean run.
    rand_mem();
    queue_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_all_zero("midrun_reset");
    exp_q.delete();
    daddr_q.delete();
    taddr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(done), 64'd0);
    do_run(0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
